// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD page sequencer and the LCD controller.
//   seq_state_t : page sequencer FSM encodings
//   CHAR_SPACE  : blank character used to clear the text buffers
//   col_msb()   : maps a character column onto the MSB of its byte in a
//                 line bus (column 0 is the leftmost, most significant byte)
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_REQ       = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_DWELL     = 3'd5
    } seq_state_t;

    localparam logic [7:0] CHAR_SPACE = 8'h20;

    function automatic int col_msb(input int cols, input int col);
        return 8 * (cols - col) - 1;
    endfunction

endpackage

// File: rtl/lcd_page_buffer.sv
// Text store for the page sequencer: PAGES pages of two COLS-character lines.
//   clk, reset          : clock, synchronous active-high reset (all bytes -> space)
//   wr_en/wr_page/wr_line/wr_col/wr_char : one-byte write port; out-of-range
//                         page or column writes are ignored
//   rd_page             : page selected for the combinational read
//   rd_line1, rd_line2  : the selected page as two 8*COLS line buses
module lcd_page_buffer
    import lcd_pkg::*;
#(
    parameter int COLS  = 16,
    parameter int PAGES = 4,
    localparam int PW   = (PAGES > 1) ? $clog2(PAGES) : 1,
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [PW-1:0]     wr_page,
    input  logic              wr_line,
    input  logic [CW-1:0]     wr_col,
    input  logic [7:0]        wr_char,
    input  logic [PW-1:0]     rd_page,
    output logic [8*COLS-1:0] rd_line1,
    output logic [8*COLS-1:0] rd_line2
);

    logic [8*COLS-1:0] line1_mem [PAGES];
    logic [8*COLS-1:0] line2_mem [PAGES];
    logic              wr_ok;

    assign wr_ok = wr_en && (int'(wr_page) < PAGES) && (int'(wr_col) < COLS);

    genvar gi;
    generate
        for (gi = 0; gi < PAGES; gi++) begin : g_page
            logic [8*COLS-1:0] l1_reg;
            logic [8*COLS-1:0] l2_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    l1_reg <= {COLS{CHAR_SPACE}};
                    l2_reg <= {COLS{CHAR_SPACE}};
                end else if (wr_ok && (int'(wr_page) == gi)) begin
                    if (wr_line)
                        l2_reg[col_msb(COLS, int'(wr_col)) -: 8] <= wr_char;
                    else
                        l1_reg[col_msb(COLS, int'(wr_col)) -: 8] <= wr_char;
                end
            end

            assign line1_mem[gi] = l1_reg;
            assign line2_mem[gi] = l2_reg;
        end
    endgenerate

    assign rd_line1 = line1_mem[rd_page];
    assign rd_line2 = line2_mem[rd_page];

endmodule

// File: rtl/lcd_page_sequencer.sv
// Presents one page of a writable two-line text buffer at a time to
// lcd_controller via its line1/line2/refresh/ready handshake. Pages advance
// after DWELL_CYCLES in auto mode or on a next_pg pulse; a write to the page
// on display forces a redraw.
//   clk, reset      : clock, synchronous active-high reset
//   wr_*            : one-byte buffer write port (accepted in every state)
//   manual          : 1 = advance only on next_pg, 0 = auto dwell
//   next_pg         : single-cycle advance request (honoured only in DWELL)
//   page_count      : active pages; 0 acts as 1, values above PAGES clamp
//   ready           : controller idle / can accept refresh
//   line1, line2    : text of the page being shown
//   refresh         : single-cycle redraw request
//   cur_page        : page displayed or being drawn
//   busy            : high from LOAD through WAIT_DONE
module lcd_page_sequencer
    import lcd_pkg::*;
#(
    parameter int COLS         = 16,
    parameter int PAGES        = 4,
    parameter int DWELL_CYCLES = 200_000_000,
    parameter int ACK_TIMEOUT  = 1024,
    localparam int PW          = (PAGES > 1) ? $clog2(PAGES) : 1,
    localparam int CW          = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int DW          = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1,
    localparam int AW          = $clog2(ACK_TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [PW-1:0]     wr_page,
    input  logic              wr_line,
    input  logic [CW-1:0]     wr_col,
    input  logic [7:0]        wr_char,
    input  logic              manual,
    input  logic              next_pg,
    input  logic [PW:0]       page_count,
    input  logic              ready,
    output logic [8*COLS-1:0] line1,
    output logic [8*COLS-1:0] line2,
    output logic              refresh,
    output logic [PW-1:0]     cur_page,
    output logic              busy
);

    seq_state_t        state_reg, state_next;
    logic [PW-1:0]     cur_page_reg;
    logic [8*COLS-1:0] line1_reg, line2_reg;
    logic [8*COLS-1:0] rd_line1, rd_line2;
    logic              refresh_reg, busy_reg, dirty_reg;
    logic [AW-1:0]     ack_cnt_reg;
    logic [DW-1:0]     dwell_cnt_reg;

    logic              wr_hit, advance, ack_expired, dwell_expired;
    logic [PW-1:0]     next_page;
    int                eff_count;

    lcd_page_buffer #(
        .COLS  (COLS),
        .PAGES (PAGES)
    ) u_buffer (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_page  (wr_page),
        .wr_line  (wr_line),
        .wr_col   (wr_col),
        .wr_char  (wr_char),
        .rd_page  (cur_page_reg),
        .rd_line1 (rd_line1),
        .rd_line2 (rd_line2)
    );

    assign wr_hit = wr_en && (int'(wr_page) < PAGES) && (int'(wr_col) < COLS)
                    && (wr_page == cur_page_reg);

    // The ack counter is cleared in REQ, so it lags the cycles elapsed since
    // the pulse by one; retrying at ACK_TIMEOUT-2 spaces the pulses exactly
    // ACK_TIMEOUT cycles apart.
    assign ack_expired   = int'(ack_cnt_reg) >= (ACK_TIMEOUT - 2);
    // >= rather than == so a count that saturated during manual mode still
    // expires straight away after switching back to auto.
    assign dwell_expired = !manual && (int'(dwell_cnt_reg) >= (DWELL_CYCLES - 1));

    always_comb begin
        eff_count = int'(page_count);
        if (eff_count == 0)
            eff_count = 1;
        else if (eff_count > PAGES)
            eff_count = PAGES;
        if (int'(cur_page_reg) + 1 >= eff_count)
            next_page = '0;
        else
            next_page = cur_page_reg + PW'(1);
    end

    always_comb begin
        state_next = state_reg;
        advance    = 1'b0;
        case (state_reg)
            ST_IDLE:      if (ready) state_next = ST_LOAD;
            ST_LOAD:      state_next = ST_REQ;
            ST_REQ:       state_next = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (!ready)
                    state_next = ST_WAIT_DONE;
                else if (ack_expired)
                    state_next = ST_REQ;
            end
            ST_WAIT_DONE: if (ready) state_next = ST_DWELL;
            ST_DWELL: begin
                // An advance outranks a pending redraw: the new page is loaded
                // fresh anyway. next_pg and expiry together give one advance.
                if (next_pg || dwell_expired) begin
                    advance    = 1'b1;
                    state_next = ST_LOAD;
                end else if (dirty_reg) begin
                    state_next = ST_LOAD;
                end
            end
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cur_page_reg  <= '0;
            line1_reg     <= {COLS{CHAR_SPACE}};
            line2_reg     <= {COLS{CHAR_SPACE}};
            refresh_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            dirty_reg     <= 1'b0;
            ack_cnt_reg   <= '0;
            dwell_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            refresh_reg <= (state_next == ST_REQ);
            busy_reg    <= state_next inside {ST_LOAD, ST_REQ, ST_WAIT_ACK, ST_WAIT_DONE};

            if (advance)
                cur_page_reg <= next_page;

            if (state_reg == ST_LOAD) begin
                line1_reg <= rd_line1;
                line2_reg <= rd_line2;
            end

            // A write landing in the LOAD cycle itself may have missed the
            // snapshot, so setting dirty takes priority over clearing it.
            if (wr_hit)
                dirty_reg <= 1'b1;
            else if (state_reg == ST_LOAD)
                dirty_reg <= 1'b0;

            if (state_reg == ST_REQ)
                ack_cnt_reg <= '0;
            else if (state_reg == ST_WAIT_ACK)
                ack_cnt_reg <= ack_cnt_reg + AW'(1);

            if (state_reg == ST_WAIT_DONE)
                dwell_cnt_reg <= '0;
            else if (state_reg == ST_DWELL && dwell_cnt_reg != '1)
                dwell_cnt_reg <= dwell_cnt_reg + DW'(1);
        end
    end

    assign line1    = line1_reg;
    assign line2    = line2_reg;
    assign refresh  = refresh_reg;
    assign cur_page = cur_page_reg;
    assign busy     = busy_reg;

endmodule
